// File: rtl/writeback_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | constant : shared opcode/funct codes and writeback-stage types           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package constant;

  // Instruction class, as driven by execute on op_type.
  localparam logic [1:0] OPT_IMM  = 2'b00;
  localparam logic [1:0] OPT_REG  = 2'b01;
  localparam logic [1:0] OPT_FPU  = 2'b10;
  localparam logic [1:0] OPT_MISC = 2'b11;

  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2b;
  localparam logic [5:0] OP_LW_S   = 6'h31;
  localparam logic [5:0] OP_IN     = 6'h3c;
  localparam logic [5:0] OP_OUT    = 6'h3d;

  localparam logic [5:0] FUNC_ADD  = 6'h20;
  localparam logic [5:0] FUNC_SUB  = 6'h22;
  localparam logic [5:0] FUNC_SUBU = 6'h23;

  localparam logic [5:0] FPU_ADD   = 6'h00;
  localparam logic [5:0] FPU_MUL   = 6'h02;
  localparam logic [5:0] FPU_INV   = 6'h04;
  localparam logic [5:0] FPU_SQRT  = 6'h05;

  localparam logic [1:0] RW_NONE   = 2'd0;
  localparam logic [1:0] RW_INT    = 2'd1;
  localparam logic [1:0] RW_FP     = 2'd2;

  typedef enum logic [2:0] {LC_ALU, LC_LOAD, LC_FINV, LC_FSQRT, LC_UART} lat_class_t;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_UART} wb_state_t;

  // Integer r0 is hardwired and code 3 names no register file.
  function automatic logic [1:0] wb_gate_rw(input logic [1:0] rw, input logic [4:0] rd);
    if ((rw == RW_INT && rd == 5'd0) || rw == 2'd3)
      return RW_NONE;
    return rw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/writeback_lat_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_lat_decode : maps op_type/instr to the instruction's latency class    |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module wb_lat_decode
  import constant::*;
(
  input  logic [1:0]  op_type,
  input  logic [5:0]  instr,
  output lat_class_t  lat_class
);

  always_comb begin
    lat_class = LC_ALU;
    if (op_type == OPT_IMM) begin
      if (instr == OP_LW || instr == OP_LW_S)
        lat_class = LC_LOAD;
      else if (instr == OP_IN || instr == OP_OUT)
        lat_class = LC_UART;
    end else if (op_type == OPT_FPU) begin
      if (instr == FPU_INV)
        lat_class = LC_FINV;
      else if (instr == FPU_SQRT)
        lat_class = LC_FSQRT;
    end
  end

endmodule
`default_nettype wire

// File: rtl/writeback.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | writeback : tracks the in-flight instruction and commits the ew_* bundle |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module writeback
  import constant::*;
#(
  parameter int          LOAD_LAT  = 2,
  parameter int          FINV_LAT  = 2,
  parameter int          FSQRT_LAT = 2,
  parameter logic [31:0] PC_RESET  = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue,
  input  logic [5:0]  instr,
  input  logic [1:0]  op_type,
  input  logic [4:0]  rd,
  input  logic [1:0]  rw,
  input  logic [31:0] d_in,
  input  logic [31:0] npc_in,
  input  logic        uart_busy,
  output logic        ready,
  output logic [31:0] ew_d,
  output logic [1:0]  ew_rw,
  output logic [4:0]  ew_rd,
  output logic [31:0] pc,
  output logic        retire,
  output logic [31:0] retired_count
);

  generate
    if (LOAD_LAT < 1 || LOAD_LAT > 7 || FINV_LAT < 1 || FINV_LAT > 7 ||
        FSQRT_LAT < 1 || FSQRT_LAT > 7) begin : g_bad_latency
      $error("writeback: latency parameters must lie in 1..7");
    end
  endgenerate

  localparam logic [2:0] c_load_lat  = LOAD_LAT[2:0];
  localparam logic [2:0] c_finv_lat  = FINV_LAT[2:0];
  localparam logic [2:0] c_fsqrt_lat = FSQRT_LAT[2:0];

  wb_state_t   r_state;
  wb_state_t   w_state_nxt;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;
  logic [5:0]  r_instr;
  logic [1:0]  r_op_type;
  logic [4:0]  r_rd;
  logic [1:0]  r_rw;
  logic        w_commit;
  logic        w_latch;
  logic [2:0]  w_lat;
  logic [5:0]  w_instr_c;
  logic [1:0]  w_op_type_c;
  logic [4:0]  w_rd_c;
  logic [1:0]  w_rw_c;
  lat_class_t  w_class;

  logic [31:0] r_ew_d;
  logic [1:0]  r_ew_rw;
  logic [4:0]  r_ew_rd;
  logic [31:0] r_pc;
  logic        r_retire;
  logic [31:0] r_retired_count;

  // In IDLE the instruction is still on the inputs; afterwards use the latched copy.
  assign w_instr_c   = (r_state == ST_IDLE) ? instr   : r_instr;
  assign w_op_type_c = (r_state == ST_IDLE) ? op_type : r_op_type;
  assign w_rd_c      = (r_state == ST_IDLE) ? rd      : r_rd;
  assign w_rw_c      = (r_state == ST_IDLE) ? rw      : r_rw;

  wb_lat_decode u_lat_decode (
    .op_type   (w_op_type_c),
    .instr     (w_instr_c),
    .lat_class (w_class)
  );

  always_comb begin
    w_lat = 3'd1;
    case (w_class)
      LC_LOAD:  w_lat = c_load_lat;
      LC_FINV:  w_lat = c_finv_lat;
      LC_FSQRT: w_lat = c_fsqrt_lat;
      default:  w_lat = 3'd1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 3'd0;
      r_instr   <= 6'd0;
      r_op_type <= 2'd0;
      r_rd      <= 5'd0;
      r_rw      <= RW_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) begin
        r_instr   <= instr;
        r_op_type <= op_type;
        r_rd      <= rd;
        r_rw      <= rw;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (issue) begin
          w_latch = 1'b1;
          if (w_class == LC_UART) begin
            w_state_nxt = ST_UART;
          end else if (w_lat > 3'd1) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = w_lat - 3'd1;
          end else begin
            w_commit = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == 3'd1) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      ST_UART: begin
        if (!uart_busy) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ew_d          <= 32'd0;
      r_ew_rw         <= RW_NONE;
      r_ew_rd         <= 5'd0;
      r_pc            <= PC_RESET;
      r_retire        <= 1'b0;
      r_retired_count <= 32'd0;
    end else begin
      r_retire <= w_commit;
      r_ew_rw  <= w_commit ? wb_gate_rw(w_rw_c, w_rd_c) : RW_NONE;
      if (w_commit) begin
        r_ew_d          <= d_in;
        r_ew_rd         <= w_rd_c;
        r_pc            <= npc_in;
        r_retired_count <= r_retired_count + 32'd1;
      end
    end
  end

  assign ready         = (r_state == ST_IDLE);
  assign ew_d          = r_ew_d;
  assign ew_rw         = r_ew_rw;
  assign ew_rd         = r_ew_rd;
  assign pc            = r_pc;
  assign retire        = r_retire;
  assign retired_count = r_retired_count;

endmodule
`default_nettype wire
